step_ctrl: RTL and testbench
============================

# step_ctrl

Single-step / free-run controller for the CPU clock enable. Consumes the debounced switch level from the upstream button debouncer and sequences the CPU: a short press issues exactly one clock-enable pulse, a long press enters free-run mode at a programmable rate, and a further press or a CPU halt request stops it. Sits between the debouncer and the CPU core's global clock-enable input.

## Interface
- LONG_CNT, 50_000_000: hold cycles in PRESS that qualify a long press; legal range ≥ 2.
- RUN_DIV, 1: free-run rate. One cpu_en pulse every RUN_DIV cycles; 1 means continuous. Legal range ≥ 1.
- CNT_W, 32: width of the hold and divider counters. Must hold LONG_CNT-1 and RUN_DIV-1.

- clk, input, 1: system clock.
- rst_n, input, 1: reset. Asynchronous, active-low.
- btn_lvl, input, 1: debounced button level, high = pressed. Synchronous to clk.
- halt_req, input, 1: CPU halt request. Level- or pulse-sampled each cycle.
- cpu_en, output, 1: CPU clock enable. Registered.
- run_mode, output, 1: high while in RUN. Registered.
- step_cnt, output, 16: count of cpu_en pulses issued. Registered.

## Operation
- btn_q is btn_lvl registered. press = btn_lvl & ~btn_q (combinational).
- FSM states:
  - IDLE: default state.
  - PRESS: counting hold cycles.
  - STEP: one-cycle pulse state.
  - RUN: free-run state.
  - WAIT_REL: waiting for button release.
- IDLE:
  - press → PRESS, with hold_cnt cleared to 0.
  - halt_req is ignored.
- PRESS:
  - hold_cnt increments every cycle.
  - btn_lvl == 0 → STEP.
  - Otherwise hold_cnt == LONG_CNT-1 → RUN, with div_cnt cleared to 0.
  - If release and hold_cnt == LONG_CNT-1 occur in the same cycle, release wins → STEP.
  - halt_req is ignored.
- STEP:
  - Always → IDLE after one cycle.
  - halt_req is ignored; the step completes.
- RUN:
  - div_cnt counts 0..RUN_DIV-1 and wraps.
  - halt_req → IDLE if btn_lvl == 0, else WAIT_REL.
  - Otherwise press → WAIT_REL.
  - If halt_req and press occur in the same cycle, halt_req wins; the button is high, so → WAIT_REL.
  - The long-press hold that entered RUN is not a press edge. Stopping RUN needs a release followed by a new press.
- WAIT_REL:
  - btn_lvl == 0 → IDLE.
  - No cpu_en pulses are issued.
- Outputs are registered from the next-state decode, so they change on the same edge as the state.
- cpu_en = 1 when:
  - next state is STEP, or
  - next state is RUN and next div_cnt == RUN_DIV-1.
- run_mode = (next state == RUN).
- step_cnt increments by 1 on every cycle where cpu_en is registered high. It wraps 16'hFFFF → 0.
- Reset value of every output is 0: cpu_en = 0, run_mode = 0, step_cnt = 0. FSM resets to IDLE, counters to 0, btn_q to 0.
- Reset asserted mid-operation clears everything immediately (asynchronous). After release, a button still held is not a press until it is seen low then high.

## Timing
- Short press:
  - btn_lvl rises at edge T. State is PRESS from edge T+1.
  - Release is sampled at edge R. STEP and cpu_en = 1 from edge R, for exactly one cycle. IDLE from edge R+1.
- Long press:
  - RUN is entered at the edge where hold_cnt == LONG_CNT-1 is sampled, i.e. LONG_CNT cycles after entering PRESS.
  - First cpu_en occurs RUN_DIV-1 cycles after RUN entry. With RUN_DIV = 1 it is high in the first RUN cycle and then continuous.
- Stop:
  - A press or halt_req sampled at edge S drops cpu_en and run_mode from edge S.
  - No pulse is issued after S.
- step_cnt is updated one cycle after the corresponding cpu_en cycle.

## Configuration
- STEP_CNT_EN defined: step_cnt counter implemented as described.
- STEP_CNT_EN undefined: step_cnt tied to 16'd0, counter logic removed. FSM and cpu_en behaviour are unchanged.

## Structure
- Package step_ctrl_pkg holds:
  - state encodings: IDLE = 3'd0, PRESS = 3'd1, STEP = 3'd2, RUN = 3'd3, WAIT_REL = 3'd4;
  - the default CNT_W;
  - the step_cnt width constant (16).
- One sub-module, step_rate_div:
  - holds the RUN_DIV divider;
  - inputs: clear, enable;
  - output: tick (next-state aligned).
- The FSM, hold counter and step counter stay in step_ctrl.

## Test plan
Bench uses LONG_CNT = 8, RUN_DIV = 3.
- Reset: rst_n low with btn_lvl high → cpu_en = 0, run_mode = 0, step_cnt = 0. After release, no PRESS until btn_lvl goes low then high.
- Short press: btn_lvl high 3 cycles, then low → exactly one 1-cycle cpu_en at the release edge, step_cnt = 1, run_mode stays 0.
- Long press: btn_lvl high 20 cycles → run_mode rises 8 cycles after PRESS entry. cpu_en is high every 3rd cycle. Release does not stop RUN. A new press drops cpu_en and run_mode on the same edge; IDLE follows after release.
- Boundary: release sampled exactly when hold_cnt == 7 → STEP (one pulse), not RUN.
- Halt: halt_req pulse in RUN with btn_lvl low → IDLE next edge, no further cpu_en. halt_req together with a press → WAIT_REL, then IDLE after release.
- Wrap and async reset: preload run of 65 536 pulses (RUN_DIV = 1) → step_cnt wraps to 0. Then assert rst_n low mid-RUN → all outputs 0 immediately.

Source files
------------

// File: rtl/step_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : step_ctrl_pkg
// Description : Shared types and constants for the single-step / free-run
//               CPU clock-enable controller (state encoding, default counter
//               width, step counter width).
// Revision    : 1.0 - initial release
// ============================================================================
package step_ctrl_pkg;

    // Default width of the hold and divider counters
    localparam int C_CNT_W_DEF  = 32;

    // Width of the issued-pulse counter
    localparam int C_STEP_CNT_W = 16;

    // Controller state encoding
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS    = 3'd1,
        STEP     = 3'd2,
        RUN      = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

endpackage : step_ctrl_pkg
`default_nettype wire

// File: rtl/step_rate_div.sv
`default_nettype none
// ============================================================================
// Module      : step_rate_div
// Description : Free-run rate divider. Counts 0..RUN_DIV-1 and wraps while
//               enabled. The tick output is decoded from the counter's NEXT
//               value so the parent can register it alongside its next state.
// Ports       : clk     - system clock
//               rst_n   - asynchronous active-low reset
//               clear   - load counter with 0 (RUN entry)
//               enable  - advance counter (staying in RUN)
//               tick    - next counter value equals RUN_DIV-1
// Revision    : 1.0 - initial release
// ============================================================================
module step_rate_div
    import step_ctrl_pkg::*;
#(
    parameter int RUN_DIV = 1,
    parameter int CNT_W   = C_CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [CNT_W-1:0] C_DIV_LAST = CNT_W'(RUN_DIV - 1);

    logic [CNT_W-1:0] r_div_cnt;
    logic [CNT_W-1:0] w_div_nxt;

    always_comb begin
        w_div_nxt = r_div_cnt;
        if (clear) begin
            w_div_nxt = '0;
        end else if (enable) begin
            w_div_nxt = (r_div_cnt == C_DIV_LAST) ? '0 : r_div_cnt + CNT_W'(1);
        end
        tick = (w_div_nxt == C_DIV_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= w_div_nxt;
        end
    end

endmodule : step_rate_div
`default_nettype wire

// File: rtl/step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : step_ctrl
// Description : Single-step / free-run controller for the CPU clock enable.
//               A short button press issues one cpu_en pulse; a press held
//               for LONG_CNT cycles enters free-run at one pulse every
//               RUN_DIV cycles. A new press or halt_req stops free-run.
// Ports       : clk       - system clock
//               rst_n     - asynchronous active-low reset
//               btn_lvl   - debounced button level (1 = pressed)
//               halt_req  - CPU halt request, sampled every cycle
//               cpu_en    - registered CPU clock enable
//               run_mode  - registered, high while free-running
//               step_cnt  - registered count of cpu_en pulses (wraps)
// Config      : STEP_CNT_EN - when defined, step_cnt counts pulses;
//               otherwise step_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int LONG_CNT = 50_000_000,
    parameter int RUN_DIV  = 1,
    parameter int CNT_W    = C_CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    btn_lvl,
    input  logic                    halt_req,
    output logic                    cpu_en,
    output logic                    run_mode,
    output logic [C_STEP_CNT_W-1:0] step_cnt
);

    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(LONG_CNT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_btn_q;
    logic             r_btn_vld;
    logic             w_press;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             w_div_clear;
    logic             w_div_en;
    logic             w_tick;
    logic             r_cpu_en;
    logic             r_run_mode;

    // r_btn_vld stays low for the first cycle after reset so that a button
    // held through reset is not mistaken for a fresh rising edge.
    assign w_press = btn_lvl & ~r_btn_q & r_btn_vld;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_press) begin
                    w_state_nxt = PRESS;
                end
            end
            PRESS: begin
                // Release has priority over reaching the long-press count
                if (!btn_lvl) begin
                    w_state_nxt = STEP;
                end else if (r_hold_cnt == C_HOLD_LAST) begin
                    w_state_nxt = RUN;
                end
            end
            STEP: begin
                w_state_nxt = IDLE;
            end
            RUN: begin
                // Halt has priority; with the button still down we must wait
                // for release so the held button is not read as a new press.
                if (halt_req) begin
                    w_state_nxt = btn_lvl ? WAIT_REL : IDLE;
                end else if (w_press) begin
                    w_state_nxt = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!btn_lvl) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_div_clear = (r_state == PRESS) && (w_state_nxt == RUN);
    assign w_div_en    = (r_state == RUN)   && (w_state_nxt == RUN);

    step_rate_div #(
        .RUN_DIV (RUN_DIV),
        .CNT_W   (CNT_W)
    ) u_rate_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_div_clear),
        .enable (w_div_en),
        .tick   (w_tick)
    );

    // State, hold counter and outputs all register from the next-state
    // decode so the outputs change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_btn_q    <= 1'b0;
            r_btn_vld  <= 1'b0;
            r_hold_cnt <= '0;
            r_cpu_en   <= 1'b0;
            r_run_mode <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_btn_q   <= btn_lvl;
            r_btn_vld <= 1'b1;
            if ((r_state == IDLE) && w_press) begin
                r_hold_cnt <= '0;
            end else if (r_state == PRESS) begin
                r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            end
            r_cpu_en   <= (w_state_nxt == STEP) || ((w_state_nxt == RUN) && w_tick);
            r_run_mode <= (w_state_nxt == RUN);
        end
    end

    assign cpu_en   = r_cpu_en;
    assign run_mode = r_run_mode;

`ifdef STEP_CNT_EN
    logic [C_STEP_CNT_W-1:0] r_step_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_cnt <= '0;
        end else if (r_cpu_en) begin
            r_step_cnt <= r_step_cnt + C_STEP_CNT_W'(1);
        end
    end

    assign step_cnt = r_step_cnt;
`else
    assign step_cnt = '0;
`endif

endmodule : step_ctrl
`default_nettype wire

// File: tb/tb_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_ctrl
// Description : Self-checking bench for step_ctrl. A behavioural model
//               predicts each cycle's outputs into a scoreboard queue that a
//               separate monitor drains and compares. A second instance with
//               RUN_DIV = 1 exercises step_cnt wrap and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_step_ctrl;

    localparam int LONG_CNT = 8;
    localparam int RUN_DIV  = 3;
`ifdef STEP_CNT_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        btn_lvl  = 1'b0;
    logic        halt_req = 1'b0;
    logic        btn1     = 1'b0;
    logic        halt1    = 1'b0;
    logic        cpu_en, run_mode;
    logic [15:0] step_cnt;
    logic        cpu_en1, run_mode1;
    logic [15:0] step_cnt1;

    always #5 clk = ~clk;

    step_ctrl #(.LONG_CNT(LONG_CNT), .RUN_DIV(RUN_DIV), .CNT_W(32)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_lvl  (btn_lvl),
        .halt_req (halt_req),
        .cpu_en   (cpu_en),
        .run_mode (run_mode),
        .step_cnt (step_cnt)
    );

    step_ctrl #(.LONG_CNT(LONG_CNT), .RUN_DIV(1), .CNT_W(32)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_lvl  (btn1),
        .halt_req (halt1),
        .cpu_en   (cpu_en1),
        .run_mode (run_mode1),
        .step_cnt (step_cnt1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        en;
        logic        run;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_HOLD = 1, M_STEP = 2, M_RUN = 3, M_WAIT = 4;
    int m_mode     = M_IDLE;
    int m_held     = 0;   // cycles held since the press was seen
    int m_age      = 0;   // cycles since free-run started
    int m_steps    = 0;   // pulses counted so far (mod 2^16)
    bit m_prev_btn = 1'b0;
    bit m_prev_vld = 1'b0;
    bit m_en_prev  = 1'b0;

    // Predict the outputs after the coming clock edge, given the inputs.
    task automatic model_step(input bit rst_ok, input bit b, input bit h);
        exp_t e;
        bit   press;
        bit   en;
        if (!rst_ok) begin
            m_mode = M_IDLE; m_held = 0; m_age = 0; m_steps = 0;
            m_prev_btn = 1'b0; m_prev_vld = 1'b0; m_en_prev = 1'b0;
            e = '0;
            sb_q.push_back(e);
            return;
        end
        press   = b && m_prev_vld && !m_prev_btn;
        m_steps = (m_steps + int'(m_en_prev)) % 65536;
        case (m_mode)
            M_IDLE: if (press) begin m_mode = M_HOLD; m_held = 0; end
            M_HOLD: begin
                if (!b) m_mode = M_STEP;
                else if (m_held == LONG_CNT - 1) begin m_mode = M_RUN; m_age = 0; end
                else m_held++;
            end
            M_STEP: m_mode = M_IDLE;
            M_RUN: begin
                if (h) m_mode = b ? M_WAIT : M_IDLE;
                else if (press) m_mode = M_WAIT;
                else m_age++;
            end
            default: if (!b) m_mode = M_IDLE;
        endcase
        en = (m_mode == M_STEP) || ((m_mode == M_RUN) && ((m_age + 1) % RUN_DIV == 0));
        e.en  = en;
        e.run = (m_mode == M_RUN);
        e.cnt = STEP_EN ? 16'(m_steps) : 16'd0;
        sb_q.push_back(e);
        m_en_prev  = en;
        m_prev_btn = b;
        m_prev_vld = 1'b1;
    endtask

    // One clock cycle of stimulus; inputs change 1 time unit after posedge.
    task automatic cycle(input bit b, input bit h, input bit b1);
        btn_lvl  = b;
        halt_req = h;
        btn1     = b1;
        model_step(rst_n, b, h);
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n, input bit b, input bit h);
        for (int i = 0; i < n; i++) cycle(b, h, 1'b0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("cpu_en",   16'(cpu_en),   16'(e.en));
                chk("run_mode", 16'(run_mode), 16'(e.run));
                chk("step_cnt", step_cnt,      e.cnt);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset with the button held; held button after release is no press
        cycles(3, 1'b1, 1'b0);
        rst_n = 1'b1;
        cycles(12, 1'b1, 1'b0);
        cycles(2, 1'b0, 1'b0);

        // Short press
        cycles(3, 1'b1, 1'b0);
        cycles(3, 1'b0, 1'b0);

        // Long press, release keeps running, new press stops
        cycles(20, 1'b1, 1'b0);
        cycles(10, 1'b0, 1'b0);
        cycles(3, 1'b1, 1'b0);
        cycles(3, 1'b0, 1'b0);

        // Boundary: release exactly when hold count reaches LONG_CNT-1
        cycles(8, 1'b1, 1'b0);
        cycles(3, 1'b0, 1'b0);

        // Halt with button low
        cycles(9, 1'b1, 1'b0);
        cycles(5, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycles(5, 1'b0, 1'b0);

        // Halt coinciding with a press
        cycles(9, 1'b1, 1'b0);
        cycles(5, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycles(2, 1'b1, 1'b0);
        cycles(3, 1'b0, 1'b0);

        // Randomised episodes: press lengths around the long-press threshold
        for (int ep = 0; ep < 80; ep++) begin
            int hold_len;
            int gap_len;
            hold_len = $urandom_range(1, 14);
            gap_len  = $urandom_range(1, 12);
            for (int i = 0; i < hold_len; i++)
                cycle(1'b1, ($urandom_range(0, 9) == 0), 1'b0);
            for (int i = 0; i < gap_len; i++)
                cycle(1'b0, ($urandom_range(0, 7) == 0), 1'b0);
        end

        // Bring the main instance back to idle
        cycle(1'b0, 1'b1, 1'b0);
        cycles(4, 1'b0, 1'b0);

        // Wrap: both instances long-pressed; second one runs continuously
        for (int i = 0; i < LONG_CNT + 1; i++) cycle(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        chk("run1_entry_cpu_en",   16'(cpu_en1),   16'd1);
        chk("run1_entry_run_mode", 16'(run_mode1), 16'd1);
        chk("run1_entry_step_cnt", step_cnt1,      16'd0);
        for (int i = 0; i < 65535; i++) cycle(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("run1_cnt_ffff", step_cnt1, STEP_EN ? 16'hFFFF : 16'd0);
        cycle(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("run1_cnt_wrap", step_cnt1,      16'd0);
        chk("run1_still_on", 16'(run_mode1), 16'd1);

        // Asynchronous reset mid-run
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_cpu_en",    16'(cpu_en),    16'd0);
        chk("arst_run_mode",  16'(run_mode),  16'd0);
        chk("arst_step_cnt",  step_cnt,       16'd0);
        chk("arst_cpu_en1",   16'(cpu_en1),   16'd0);
        chk("arst_run_mode1", 16'(run_mode1), 16'd0);
        chk("arst_step_cnt1", step_cnt1,      16'd0);
        cycles(2, 1'b0, 1'b0);
        rst_n = 1'b1;
        cycles(3, 1'b0, 1'b0);
        cycles(2, 1'b1, 1'b0);
        cycles(3, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_step_ctrl
`default_nettype wire
